spi_master_ram_ctrl: RTL and testbench

- SPI master that drives the SPI-slave-with-single-port-RAM block from the system side.
- Accepts one command at a time on a start/busy/done handshake and serializes a 10-bit frame `{cmd[1:0], payload[7:0]}` onto MOSI under SS_n.
- For read-data commands, deserializes the 8-bit RAM byte returned on MISO.
- Sits between a host-side controller or test sequencer and the SPI pins, and shares the slave's system clock (one bit per clk).

---
 rtl/spi_master_ram_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_spi_master_ram_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ram_ctrl.sv
// SPI master for the SPI-slave/single-port-RAM block.
// Sends one 10-bit frame {cmd, payload} per start and, for read-data (cmd 11),
// receives the returned RAM byte on MISO. Shares clk with the slave (one bit per clk).
// Optional command-order checker: define SPI_MASTER_CMD_ORDER_CHK_EN.
//
// state   | meaning
// --------|----------------------------------------------------------
// S_IDLE  | SS_n high, waiting for start
// S_LOAD  | SS_n low, slave command-check cycle, MOSI shows frame[9]
// S_SHIFT | 10 frame bits on MOSI, MSB first
// S_WAIT  | read latency before the first MISO bit (cmd 11 only)
// S_RECV  | 8 MISO bits shifted in (cmd 11 only)
// S_GAP   | SS_n high inter-frame gap, done pulse in first cycle
module spi_master_ram_ctrl #(
    parameter int RD_LATENCY = 2,
    parameter int IDLE_GAP   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] payload,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       err,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_WAIT, S_RECV, S_GAP} state_t;

    localparam logic [3:0] RL_CNT  = 4'(RD_LATENCY - 1);
    localparam logic [3:0] GAP_CNT = 4'(IDLE_GAP - 1);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [9:0] frame, frame_n;
    logic       is_rd, is_rd_n;
    logic [7:0] rx_sr;
    logic       accept;
    logic       ss_n_d, mosi_d, done_d, busy_d;

    // Next-state and down-counter; the counter holds remaining cycles minus one.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        frame_n = frame;
        is_rd_n = is_rd;
        accept  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = S_LOAD;
                    frame_n = {cmd, payload};
                    is_rd_n = (cmd == 2'b11);
                end
            end
            S_LOAD: begin
                state_n = S_SHIFT;
                cnt_n   = 4'd9;
            end
            S_SHIFT: begin
                if (cnt == 4'd0) begin
                    if (is_rd) begin
                        state_n = S_WAIT;
                        cnt_n   = RL_CNT;
                    end else begin
                        state_n = S_GAP;
                        cnt_n   = GAP_CNT;
                    end
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_n = S_RECV;
                    cnt_n   = 4'd7;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            S_RECV: begin
                if (cnt == 4'd0) begin
                    state_n = S_GAP;
                    cnt_n   = GAP_CNT;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            S_GAP: begin
                if (cnt == 4'd0) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Pin values are decoded from the next state so the registered outputs line up with it.
    always_comb begin
        ss_n_d = (state_n == S_IDLE) || (state_n == S_GAP);
        busy_d = (state_n != S_IDLE);
        done_d = (state_n == S_GAP) && (state != S_GAP);
        mosi_d = 1'b0;
        if (state_n == S_LOAD) begin
            mosi_d = frame_n[9];
        end else if (state_n == S_SHIFT) begin
            mosi_d = frame_n[cnt_n];
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            frame    <= 10'd0;
            is_rd    <= 1'b0;
            rx_sr    <= 8'h00;
            SS_n     <= 1'b1;
            MOSI     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            frame    <= frame_n;
            is_rd    <= is_rd_n;
            SS_n     <= ss_n_d;
            MOSI     <= mosi_d;
            busy     <= busy_d;
            done     <= done_d;
            rd_valid <= done_d && is_rd;
            if (state == S_RECV) begin
                rx_sr <= {rx_sr[6:0], MISO};
                // rd_data only changes when a full byte has arrived
                if (state_n == S_GAP) begin
                    rd_data <= {rx_sr[6:0], MISO};
                end
            end
        end
    end

`ifdef SPI_MASTER_CMD_ORDER_CHK_EN
    logic wa_seen, ra_seen;

    // Each data command must be preceded by its address command; err is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            wa_seen <= 1'b0;
            ra_seen <= 1'b0;
            err     <= 1'b0;
        end else if (accept) begin
            case (cmd)
                2'b00: wa_seen <= 1'b1;
                2'b01: begin
                    if (!wa_seen) err <= 1'b1;
                    wa_seen <= 1'b0;
                end
                2'b10: ra_seen <= 1'b1;
                default: begin
                    if (!ra_seen) err <= 1'b1;
                    ra_seen <= 1'b0;
                end
            endcase
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_ram_ctrl.sv
// Bench for spi_master_ram_ctrl with a behavioural SPI slave + RAM model.
module tb_spi_master_ram_ctrl;

    localparam int RL  = 2;
    localparam int GAP = 1;
`ifdef SPI_MASTER_CMD_ORDER_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [7:0] payload = 8'h00;
    logic       busy, done, rd_valid, err, SS_n, MOSI;
    logic       MISO = 1'b0;
    logic [7:0] rd_data;

    int n_chk  = 0;
    int n_fail = 0;

    spi_master_ram_ctrl #(.RD_LATENCY(RL), .IDLE_GAP(GAP)) dut (
        .clk(clk), .rst(rst), .start(start), .cmd(cmd), .payload(payload),
        .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
        .err(err), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
    );

    always #5 clk = ~clk;

    // Slave model: counts SS_n-low cycles, works at negedge (mid-cycle values).
    logic [7:0] ram [256];
    logic [9:0] srx;
    logic [7:0] addr_w, addr_r, stx;
    int         lowcnt;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        addr_w = 8'h00;
        addr_r = 8'h00;
        stx    = 8'h00;
        srx    = 10'd0;
        lowcnt = 0;
    end

    always @(negedge clk) begin
        int j;
        if (!SS_n) begin
            lowcnt = lowcnt + 1;
            if (lowcnt >= 2 && lowcnt <= 11) srx = {srx[8:0], MOSI};
            if (lowcnt == 11) begin
                case (srx[9:8])
                    2'b00: addr_w = srx[7:0];
                    2'b01: ram[addr_w] = srx[7:0];
                    2'b10: addr_r = srx[7:0];
                    default: stx = ram[addr_r];
                endcase
            end
            j = lowcnt - 12 - RL;
            if (j >= 0 && j < 8) MISO = stx[7-j];
            else MISO = 1'b0;
        end else begin
            lowcnt = 0;
            MISO   = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One full frame with cycle-exact checks; cmd/payload are scrambled after the start edge.
    task automatic run_frame(input logic [1:0] c, input logic [7:0] p, input logic [7:0] exp_rd);
        logic [9:0] f;
        int n_wait;
        f = {c, p};
        start = 1'b1; cmd = c; payload = p;
        tick();
        start = 1'b0; cmd = ~c; payload = ~p;
        chk("load_ss_n", SS_n, 1'b0);
        chk("load_busy", busy, 1'b1);
        chk("load_mosi", MOSI, f[9]);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("shift_mosi", MOSI, f[9-i]);
            chk("shift_ss_n", SS_n, 1'b0);
        end
        n_wait = (c == 2'b11) ? 8 + RL : 0;
        for (int i = 0; i < n_wait; i++) begin
            tick();
            chk("rd_ss_n", SS_n, 1'b0);
            chk("rd_mosi", MOSI, 1'b0);
            chk("early_done", done, 1'b0);
        end
        tick();
        chk("done", done, 1'b1);
        chk("rd_valid", rd_valid, c == 2'b11);
        chk("rd_data", rd_data, exp_rd);
        chk("gap_ss_n", SS_n, 1'b1);
        chk("gap_busy", busy, 1'b1);
        for (int i = 0; i < GAP; i++) begin
            tick();
            chk("done_pulse", done, 1'b0);
        end
        chk("idle_busy", busy, 1'b0);
    endtask

    typedef struct {
        logic [1:0] c;
        logic [7:0] p;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [10];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int prev_ss, fall1, fall2, cyc, nd;
        vecs[0] = '{2'b00, 8'h10, 8'h00};
        vecs[1] = '{2'b01, 8'h3C, 8'h00};
        vecs[2] = '{2'b10, 8'h10, 8'h00};
        vecs[3] = '{2'b11, 8'h00, 8'h3C};
        vecs[4] = '{2'b00, 8'hA5, 8'h3C};
        vecs[5] = '{2'b01, 8'h5A, 8'h3C};
        vecs[6] = '{2'b10, 8'hA5, 8'h3C};
        vecs[7] = '{2'b11, 8'hFF, 8'h5A};
        vecs[8] = '{2'b10, 8'h10, 8'h5A};
        vecs[9] = '{2'b11, 8'h00, 8'h3C};

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_ss_n", SS_n, 1'b1);
        chk("rst_mosi", MOSI, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        tick();

        // Explicit write-address bit pattern for A5: 0,0,1,0,1,0,0,1,0,1
        begin
            logic [9:0] pat;
            pat = 10'b0010100101;
            start = 1'b1; cmd = 2'b00; payload = 8'hA5;
            tick();
            start = 1'b0;
            for (int i = 0; i < 10; i++) begin
                tick();
                chk("a5_mosi", MOSI, pat[9-i]);
            end
            tick();
            chk("a5_done", done, 1'b1);
            tick();
        end

        // Table-driven frames through the slave model
        for (int v = 0; v < 10; v++) run_frame(vecs[v].c, vecs[v].p, vecs[v].exp_rd);
        chk("ordered_err", err, 1'b0);

        // Start pulsed at T+5 is ignored
        start = 1'b1; cmd = 2'b00; payload = 8'h33;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("ign_done", done, 1'b1);
        tick();
        chk("ign_busy", busy, 1'b0);
        tick();
        chk("ign_ss_n", SS_n, 1'b1);
        tick();
        chk("ign_ss_n2", SS_n, 1'b1);

        // Start held high: SS_n falls 13 cycles apart
        fall1 = -1; fall2 = -1; cyc = 0; prev_ss = 1;
        start = 1'b1; cmd = 2'b00; payload = 8'h44;
        while (cyc < 60 && fall2 < 0) begin
            tick();
            cyc++;
            if (prev_ss == 1 && SS_n == 1'b0) begin
                if (fall1 < 0) fall1 = cyc;
                else fall2 = cyc;
            end
            prev_ss = int'(SS_n);
        end
        start = 1'b0;
        chk("b2b_seen", (fall2 >= 0) ? 1 : 0, 1);
        chk("b2b_period", fall2 - fall1, 13);
        cyc = 0;
        while (busy && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("b2b_drain", busy, 1'b0);
        tick();

        // Mid-frame reset in a read-data frame
        chk("pre_rst_rd_data", rd_data, 8'h3C);
        start = 1'b1; cmd = 2'b11; payload = 8'h00;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ss_n", SS_n, 1'b1);
        chk("mid_rst_rd_data", rd_data, 8'h00);
        chk("mid_rst_busy", busy, 1'b0);
        nd = 0;
        repeat (30) begin
            tick();
            if (done) nd++;
        end
        chk("mid_rst_no_done", nd, 0);

        // Command-order check: read-data first after reset
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("ord_err_init", err, 1'b0);
        start = 1'b1; cmd = 2'b11; payload = 8'h00;
        tick();
        start = 1'b0;
        chk("ord_err_set", err, EXP_ERR);
        cyc = 0;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("ord_frame_done", done, 1'b1);
        tick();
        run_frame(2'b10, 8'h10, rd_data);
        chk("ord_err_sticky", err, EXP_ERR);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
